// File: rtl/riscv_vector_exec_unit.sv
// Multi-cycle vector execution unit: latches an operand pair, then computes LANES
// elements per beat over VECTOR_LENGTH/LANES beats, with a wrap-around dot accumulator.
module vec_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] scalar,
  output logic [DATA_WIDTH-1:0] res
);
  always_comb begin
    res = '0;
    case (funct3)
      3'b000:         res = a + b;
      3'b001:         res = a - b;
      3'b010, 3'b110: res = a * b;
      3'b011:         res = a & b;
      3'b100:         res = a | b;
      3'b101:         res = a ^ b;
      default:        res = a + scalar;
    endcase
  end
endmodule

module riscv_vector_exec_unit #(
  parameter int VECTOR_LENGTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int LANES         = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic [2:0]                          vector_funct3,
  input  logic [DATA_WIDTH-1:0]               scalar,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_a,
  input  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_b,
  output logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_out,
  output logic [DATA_WIDTH-1:0]               result_out,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic                                busy
);
  localparam int BEATS = VECTOR_LENGTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam logic [2:0] OP_DOT = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef logic [VECTOR_LENGTH-1:0][DATA_WIDTH-1:0] vec_t;

  state_t                state_q, state_d;
  vec_t                  a_q, a_d, b_q, b_d, vout_q, vout_d;
  logic [DATA_WIDTH-1:0] scalar_q, scalar_d, acc_q, acc_d, result_q, result_d;
  logic [2:0]            funct_q, funct_d;
  logic [BW-1:0]         beat_q, beat_d;

  logic [LANES-1:0][IW-1:0]         elem_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_res;
  logic [DATA_WIDTH-1:0]            dot_sum;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign elem_idx[l] = IW'(int'(beat_q) * LANES + l);
    vec_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .funct3 (funct_q),
      .a      (a_q[elem_idx[l]]),
      .b      (b_q[elem_idx[l]]),
      .scalar (scalar_q),
      .res    (lane_res[l])
    );
  end

  // Running dot sum: the accumulator plus this beat's lane products.
  always_comb begin
    dot_sum = acc_q;
    for (int l = 0; l < LANES; l++) dot_sum = dot_sum + lane_res[l];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    funct_d  = funct_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    vout_d   = vout_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (valid_in) begin
        a_d      = vector_a;
        b_d      = vector_b;
        scalar_d = scalar;
        funct_d  = vector_funct3;
        beat_d   = '0;
        acc_d    = '0;
        state_d  = EXEC;
      end
      EXEC: begin
        for (int l = 0; l < LANES; l++) vout_d[elem_idx[l]] = lane_res[l];
        if (funct_q == OP_DOT) begin
          acc_d    = dot_sum;
          result_d = dot_sum;
        end else if (beat_q == '0) begin
          result_d = lane_res[0];
        end
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(BEATS - 1)) state_d = DONE;
      end
      DONE: if (ready_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      funct_q  <= '0;
      beat_q   <= '0;
      acc_q    <= '0;
      vout_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      scalar_q <= scalar_d;
      funct_q  <= funct_d;
      beat_q   <= beat_d;
      acc_q    <= acc_d;
      vout_q   <= vout_d;
      result_q <= result_d;
    end
  end

  assign vector_out = vout_q;
  assign result_out = result_q;
  assign valid_out  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign ready_in   = (state_q == IDLE) && rst;
endmodule

// File: tb/tb_riscv_vector_exec_unit.sv
// Directed plus randomized checks of the vector execution unit against an element-wise
// reference model; extra instances cover LANES = 1, 4 and 8.
module tb_riscv_vector_exec_unit;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0, ready_out = 1'b0;
  logic [2:0]   funct3 = '0;
  logic [31:0]  scalar = '0;
  logic [255:0] vec_a = '0, vec_b = '0;
  logic         ready_in, valid_out, busy;
  logic [255:0] vector_out;
  logic [31:0]  result_out;

  logic [2:0]   sw_valid = '0, sw_rdy, sw_vo, sw_busy;
  logic [255:0] sw_vout [3];
  logic [31:0]  sw_res [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_vector_exec_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .vector_funct3(funct3), .scalar(scalar), .vector_a(vec_a), .vector_b(vec_b),
    .vector_out(vector_out), .result_out(result_out), .valid_out(valid_out),
    .ready_out(ready_out), .busy(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    riscv_vector_exec_unit #(.LANES(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_sw (
      .clk(clk), .rst(rst), .valid_in(sw_valid[g]), .ready_in(sw_rdy[g]),
      .vector_funct3(funct3), .scalar(scalar), .vector_a(vec_a), .vector_b(vec_b),
      .vector_out(sw_vout[g]), .result_out(sw_res[g]), .valid_out(sw_vo[g]),
      .ready_out(1'b1), .busy(sw_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = base + step * i;
    return v;
  endfunction

  // Reference: per-element result, dot summed over all products.
  function automatic void model(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                                input logic [31:0] s, output logic [255:0] v, output logic [31:0] r);
    logic [31:0] ea, eb, e;
    r = 0;
    for (int i = 0; i < 8; i++) begin
      ea = a[i*32 +: 32];
      eb = b[i*32 +: 32];
      case (op)
        3'd0: e = ea + eb;
        3'd1: e = ea - eb;
        3'd2: e = ea * eb;
        3'd3: e = ea & eb;
        3'd4: e = ea | eb;
        3'd5: e = ea ^ eb;
        3'd6: e = ea * eb;
        default: e = ea + s;
      endcase
      v[i*32 +: 32] = e;
      if (op == 3'd6) r = r + e;
    end
    if (op != 3'd6) r = v[31:0];
  endfunction

  task automatic scramble();
    for (int i = 0; i < 8; i++) begin
      vec_a[i*32 +: 32] = $urandom;
      vec_b[i*32 +: 32] = $urandom;
    end
    scalar = $urandom;
    funct3 = 3'($urandom_range(0, 7));
  endtask

  // Present an op and return #1 after its accept edge.
  task automatic accept_op(input logic [2:0] op, input logic [255:0] a, input logic [255:0] b,
                           input logic [31:0] s);
    @(negedge clk);
    funct3 = op; vec_a = a; vec_b = b; scalar = s; valid_in = 1'b1;
    for (int n = 0; n < 40 && !ready_in; n++) @(negedge clk);
    chk("accept_ready", {255'd0, ready_in}, 256'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    scramble();
  endtask

  task automatic wait_check(input string tag, input logic [255:0] ev, input logic [31:0] er);
    int lat;
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk); #1;
      if (valid_out) break;
    end
    chk({tag, "_lat"}, 256'(lat), 256'd4);
    chk({tag, "_vec"}, vector_out, ev);
    chk({tag, "_res"}, {224'd0, result_out}, {224'd0, er});
  endtask

  task automatic release_op(input string tag);
    @(negedge clk); ready_out = 1'b1;
    @(posedge clk); #1; ready_out = 1'b0;
    chk({tag, "_vo_low"}, {255'd0, valid_out}, 256'd0);
    chk({tag, "_busy_low"}, {255'd0, busy}, 256'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [255:0] a,
                     input logic [255:0] b, input logic [31:0] s);
    logic [255:0] ev;
    logic [31:0]  er;
    model(op, a, b, s, ev, er);
    accept_op(op, a, b, s);
    wait_check(tag, ev, er);
    release_op(tag);
  endtask

  task automatic sweep(input string tag, input logic [2:0] op, input logic [255:0] a,
                       input logic [255:0] b);
    logic [255:0] ev, cv [3];
    logic [31:0]  er, cr [3];
    int lat [3];
    model(op, a, b, 32'd0, ev, er);
    lat = '{0, 0, 0};
    @(negedge clk);
    funct3 = op; vec_a = a; vec_b = b; scalar = 0; sw_valid = 3'b111;
    @(posedge clk); #1;
    sw_valid = 3'b000;
    scramble();
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 3; g++)
        if (sw_vo[g] && lat[g] == 0) begin
          lat[g] = c; cv[g] = sw_vout[g]; cr[g] = sw_res[g];
        end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_l%0d_lat", tag, g), 256'(lat[g]), (g == 0) ? 256'd8 : (g == 1) ? 256'd2 : 256'd1);
      chk($sformatf("%s_l%0d_vec", tag, g), cv[g], ev);
      chk($sformatf("%s_l%0d_res", tag, g), {224'd0, cr[g]}, {224'd0, er});
    end
  endtask

  initial begin
    logic [255:0] sv, ev, ra, rb;
    logic [31:0]  sr, er;
    logic [2:0]   rop;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready_in", {255'd0, ready_in}, 256'd0);
    chk("rst_valid_out", {255'd0, valid_out}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_vec", vector_out, 256'd0);
    chk("rst_res", {224'd0, result_out}, 256'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready_in", {255'd0, ready_in}, 256'd1);

    run("add", 3'b000, fill(1, 1), fill(10, 0), 0);
    chk("add_spec", vector_out, fill(11, 1));

    accept_op(3'b110, fill(1, 1), fill(2, 0), 0);
    wait_check("dot", fill(2, 2), 32'h48);
    chk("dot_spec_res", {224'd0, result_out}, 256'h48);
    release_op("dot");

    run("wrap_add", 3'b000, fill(32'hFFFFFFFF, 0), fill(1, 0), 0);
    run("wrap_bcast", 3'b111, fill(32'hFFFFFFFE, 0), fill(0, 0), 5);

    // Backpressure with a competing request held during DONE
    model(3'b001, fill(100, 3), fill(7, 1), 0, ev, er);
    accept_op(3'b011, fill(32'h0FF0, 5), fill(32'hFF00, 9), 0);
    model(3'b011, fill(32'h0FF0, 5), fill(32'hFF00, 9), 0, sv, sr);
    wait_check("bp_first", sv, sr);
    @(negedge clk);
    funct3 = 3'b001; vec_a = fill(100, 3); vec_b = fill(7, 1); valid_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", {255'd0, valid_out}, 256'd1);
      chk("bp_vec_hold", vector_out, sv);
      chk("bp_res_hold", {224'd0, result_out}, {224'd0, sr});
      chk("bp_ready_in", {255'd0, ready_in}, 256'd0);
    end
    @(negedge clk); ready_out = 1'b1;
    @(posedge clk); #1; ready_out = 1'b0;
    chk("bp_idle_busy", {255'd0, busy}, 256'd0);
    chk("bp_idle_ready", {255'd0, ready_in}, 256'd1);
    @(posedge clk); #1;
    chk("bp_accepted", {255'd0, busy}, 256'd1);
    valid_in = 1'b0;
    scramble();
    wait_check("bp_second", ev, er);
    release_op("bp_second");

    // Reset two cycles after an accept
    accept_op(3'b000, fill(1, 1), fill(10, 0), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {255'd0, valid_out}, 256'd0);
    chk("mid_rst_busy", {255'd0, busy}, 256'd0);
    chk("mid_rst_vec", vector_out, 256'd0);
    chk("mid_rst_res", {224'd0, result_out}, 256'd0);
    chk("mid_rst_ready", {255'd0, ready_in}, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run("xor_after_rst", 3'b101, fill(32'hF0F0F0F0, 0), fill(32'hFFFFFFFF, 0), 0);
    chk("xor_spec", vector_out, fill(32'h0F0F0F0F, 0));

    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 8; i++) begin
        ra[i*32 +: 32] = $urandom;
        rb[i*32 +: 32] = $urandom;
      end
      rop = 3'($urandom_range(0, 7));
      run($sformatf("rand%0d_op%0d", t, rop), rop, ra, rb, $urandom);
    end

    sweep("sw_add", 3'b000, fill(1, 1), fill(10, 0));
    sweep("sw_dot", 3'b110, fill(1, 1), fill(2, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_vector_exec_unit.md
# riscv_vector_exec_unit

Multi-cycle, parametrised vector execution unit for the extended RISC-V processor. It supersedes the single-shot combinational vector path. It processes a VECTOR_LENGTH-element operand pair LANES elements per cycle, and supports element-wise ALU ops, scalar broadcast and a dot-product reduction. Ready/valid handshakes on both sides let the issue logic and the writeback stage stall independently.

## Interface
Parameters:
- VECTOR_LENGTH, 8, number of elements per vector; must be a multiple of LANES.
- DATA_WIDTH, 32, bits per element.
- LANES, 2, elements processed per EXEC cycle; 1 ≤ LANES ≤ VECTOR_LENGTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_in  in  1  operation request.
- ready_in  out  1  unit can accept; high only in IDLE.
- vector_funct3  in  3  operation select (see Operation).
- scalar  in  DATA_WIDTH  broadcast operand for op 111.
- vector_a  in  VECTOR_LENGTH*DATA_WIDTH  operand A; element i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- vector_b  in  VECTOR_LENGTH*DATA_WIDTH  operand B, same packing.
- vector_out  out  VECTOR_LENGTH*DATA_WIDTH  element-wise result, same packing.
- result_out  out  DATA_WIDTH  scalar result.
- valid_out  out  1  results valid; held until accepted.
- ready_out  in  1  downstream accepts results.
- busy  out  1  high in EXEC or DONE.

## Operation
- FSM states: IDLE, EXEC, DONE. BEATS = VECTOR_LENGTH/LANES.
- IDLE → EXEC when valid_in && ready_in at a rising edge:
  - vector_a, vector_b, scalar and vector_funct3 are latched into internal registers.
  - beat counter and accumulator are cleared.
  - Inputs are ignored after the accept edge.
- EXEC: each cycle, beat k computes elements k*LANES … k*LANES+LANES-1 from the latched operands and writes them into vector_out.
  - Move to DONE on the edge that completes beat BEATS-1.
- DONE: valid_out=1. On an edge with ready_out=1, move to IDLE. Outputs keep their values until the next accept.
- vector_funct3 selects the operation:
  - 000: add, a+b.
  - 001: sub, a−b.
  - 010: mul, low DATA_WIDTH bits of a*b.
  - 011: and.
  - 100: or.
  - 101: xor.
  - 110: dot, result_out = Σ a[i]*b[i]; vector_out = per-element products.
  - 111: broadcast add, a[i]+scalar.
- Width rules:
  - All arithmetic is unsigned, modulo 2^DATA_WIDTH, with no saturation or flags.
  - Dot accumulator is DATA_WIDTH bits, wrap-around.
- result_out:
  - op 110: the reduction.
  - all other ops: element 0 of vector_out.
- Reset (rst=0, any time, including mid-EXEC or in DONE):
  - State goes to IDLE immediately; the in-flight op is discarded.
  - vector_out=0, result_out=0, valid_out=0, busy=0, ready_in=1 once rst is released. While rst=0, ready_in=0.
- Simultaneous events:
  - valid_in while busy: ignored; the requester must hold it until ready_in.
  - No accept is possible in the same cycle as output acceptance; ready_in rises the cycle after the DONE→IDLE edge.

## Timing
- Accept edge E0. EXEC occupies edges E1…E_BEATS. valid_out rises after E_BEATS.
  - Defaults (BEATS=4): valid_out is high 4 cycles after the accept edge.
  - LANES=VECTOR_LENGTH: 1 cycle.
- Throughput with ready_out tied high: one op per BEATS+2 cycles.
- All outputs are registered, with no combinational path from input to output. ready_in = (state==IDLE) && rst.
- While valid_out=1 and ready_out=0, vector_out, result_out and valid_out must be bit-stable.

## Test plan
- Add, defaults:
  - Stimulus: a[i]=i+1, b[i]=10, funct3=000.
  - Required: vector_out elements 11…18, result_out=11, valid_out 4 cycles after accept.
- Dot:
  - Stimulus: a[i]=i+1, b[i]=2, funct3=110.
  - Required: result_out=0x48, vector_out elements 2,4,…,16.
- Wrap:
  - Stimulus: a[i]=0xFFFFFFFF, b[i]=1, add.
  - Required: all elements 0.
  - Stimulus: scalar=5, a[i]=0xFFFFFFFE, op 111.
  - Required: all elements 3.
- Backpressure:
  - Stimulus: ready_out=0 for 6 cycles after valid_out, with a new valid_in asserted meanwhile.
  - Required: outputs stable, ready_in=0, new op not accepted. After ready_out=1 it is accepted at the first IDLE edge.
- Reset mid-EXEC:
  - Stimulus: drive rst low two cycles after an accept.
  - Required: valid_out, busy, vector_out and result_out all go to 0 asynchronously. After release, a fresh xor op (a=0xF0F0F0F0, b=0xFFFFFFFF) gives 0x0F0F0F0F per element.
- Parameter sweep:
  - Stimulus: LANES=1, 4 and 8 with the add and dot vectors above.
  - Required: identical results; latency 8, 2 and 1 cycles respectively.
